// File: rtl/uart_rx_framer_if.sv
// Bus between a UART byte source / downstream TAP reader and the uart_rx_framer.
// Signal names carry the direction as seen from the framer (the slave side).
interface uart_rx_framer_if #(
  parameter int DEPTH = 8
);
  localparam int LVL_W = $clog2(DEPTH) + 1;

  logic             RX_VALID_I;
  logic [7:0]       RX_DATA_I;
  logic             RX_FRAME_ERR_I;
  logic             READ_I;
  logic             CLEAR_OVERFLOW_I;
  logic [7:0]       DATA_REC_O;
  logic             CMD_REC_O;
  logic             RX_EMPTY_O;
  logic             RX_FULL_O;
  logic [LVL_W-1:0] FILL_LEVEL_O;
  logic             OVERFLOW_O;

  modport slave (
    input  RX_VALID_I, RX_DATA_I, RX_FRAME_ERR_I, READ_I, CLEAR_OVERFLOW_I,
    output DATA_REC_O, CMD_REC_O, RX_EMPTY_O, RX_FULL_O, FILL_LEVEL_O, OVERFLOW_O
  );

  modport master (
    output RX_VALID_I, RX_DATA_I, RX_FRAME_ERR_I, READ_I, CLEAR_OVERFLOW_I,
    input  DATA_REC_O, CMD_REC_O, RX_EMPTY_O, RX_FULL_O, FILL_LEVEL_O, OVERFLOW_O
  );
endinterface

// File: rtl/uart_rx_framer.sv
// UART receive framer: strips escape sequences from the byte stream and queues
// {cmd, byte} entries in a show-ahead FIFO with a sticky overflow flag.
module uart_rx_framer #(
  parameter int         DEPTH    = 8,
  parameter logic [7:0] ESC_BYTE = 8'h01
) (
  input logic             CLK_I,
  input logic             RST_NI,
  uart_rx_framer_if.slave bus
);
  localparam int AW = $clog2(DEPTH);
  localparam int PW = AW + 1;
  localparam logic [PW-1:0] PTR_ONE = {{AW{1'b0}}, 1'b1};

  typedef enum logic [0:0] {
    ST_IDLE    = 1'b0,
    ST_ESCAPED = 1'b1
  } state_e;

  state_e        state_q, state_d;
  logic [8:0]    mem_q [DEPTH];
  logic [PW-1:0] wptr_q, wptr_d;
  logic [PW-1:0] rptr_q, rptr_d;
  logic          overflow_q, overflow_d;

  logic          push_s;
  logic [8:0]    push_entry_s;
  logic          empty_s, full_s;
  logic          do_push_s, do_pop_s, drop_s;
  logic [8:0]    head_s;

  // FSM state register
  always_ff @(posedge CLK_I or negedge RST_NI) begin
    if (!RST_NI) begin
      state_q <= ST_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // FSM next state: only valid bytes advance; a framing error always resynchronises to IDLE
  always_comb begin
    state_d = state_q;
    if (bus.RX_VALID_I) begin
      if (bus.RX_FRAME_ERR_I) begin
        state_d = ST_IDLE;
      end else begin
        case (state_q)
          ST_IDLE: begin
            if (bus.RX_DATA_I == ESC_BYTE) begin
              state_d = ST_ESCAPED;
            end else begin
              state_d = ST_IDLE;
            end
          end
          ST_ESCAPED: state_d = ST_IDLE;
          default:    state_d = ST_IDLE;
        endcase
      end
    end else begin
      state_d = state_q;
    end
  end

  // FSM outputs: which entry, if any, the current byte produces
  always_comb begin
    push_s       = 1'b0;
    push_entry_s = 9'h000;
    if (bus.RX_VALID_I && !bus.RX_FRAME_ERR_I) begin
      case (state_q)
        ST_IDLE: begin
          if (bus.RX_DATA_I != ESC_BYTE) begin
            push_s       = 1'b1;
            push_entry_s = {1'b0, bus.RX_DATA_I};
          end else begin
            push_s       = 1'b0;
          end
        end
        ST_ESCAPED: begin
          // Escaped escape byte is a literal; anything else is a command
          push_s       = 1'b1;
          push_entry_s = {(bus.RX_DATA_I != ESC_BYTE), bus.RX_DATA_I};
        end
        default: begin
          push_s       = 1'b0;
        end
      endcase
    end else begin
      push_s = 1'b0;
    end
  end

  assign empty_s   = (wptr_q == rptr_q);
  assign full_s    = (wptr_q[AW] != rptr_q[AW]) && (wptr_q[AW-1:0] == rptr_q[AW-1:0]);
  assign do_pop_s  = bus.READ_I && !empty_s;
  // A pop in the same cycle frees the slot, so a push on a full FIFO still lands
  assign do_push_s = push_s && (!full_s || do_pop_s);
  assign drop_s    = push_s && full_s && !do_pop_s;

  // Pointer and overflow next-state; a new overflow beats a same-cycle clear
  always_comb begin
    wptr_d     = wptr_q;
    rptr_d     = rptr_q;
    overflow_d = overflow_q;
    if (do_push_s) begin
      wptr_d = wptr_q + PTR_ONE;
    end else begin
      wptr_d = wptr_q;
    end
    if (do_pop_s) begin
      rptr_d = rptr_q + PTR_ONE;
    end else begin
      rptr_d = rptr_q;
    end
    if (drop_s) begin
      overflow_d = 1'b1;
    end else if (bus.CLEAR_OVERFLOW_I) begin
      overflow_d = 1'b0;
    end else begin
      overflow_d = overflow_q;
    end
  end

  // Pointer and overflow registers
  always_ff @(posedge CLK_I or negedge RST_NI) begin
    if (!RST_NI) begin
      wptr_q     <= {PW{1'b0}};
      rptr_q     <= {PW{1'b0}};
      overflow_q <= 1'b0;
    end else begin
      wptr_q     <= wptr_d;
      rptr_q     <= rptr_d;
      overflow_q <= overflow_d;
    end
  end

  // Storage array; contents are don't-care after reset because the pointers gate visibility
  always_ff @(posedge CLK_I) begin
    if (do_push_s) begin
      mem_q[wptr_q[AW-1:0]] <= push_entry_s;
    end
  end

  // Show-ahead head, forced to zero while empty
  always_comb begin
    head_s = 9'h000;
    if (!empty_s) begin
      head_s = mem_q[rptr_q[AW-1:0]];
    end else begin
      head_s = 9'h000;
    end
  end

  assign bus.DATA_REC_O   = head_s[7:0];
  assign bus.CMD_REC_O    = head_s[8];
  assign bus.RX_EMPTY_O   = empty_s;
  assign bus.RX_FULL_O    = full_s;
  assign bus.FILL_LEVEL_O = wptr_q - rptr_q;
  assign bus.OVERFLOW_O   = overflow_q;

endmodule

// File: tb/tb_uart_rx_framer.sv
// Self-checking bench for uart_rx_framer: table-driven de-escape vectors feeding a
// scoreboard queue, plus directed overflow, simultaneous push/pop and async-reset sequences.
module tb_uart_rx_framer;
  localparam int DEPTH = 8;

  logic clk;
  logic rst_n;
  int   n_total;
  int   n_pass;

  typedef struct {
    logic       ferr;
    logic [7:0] data;
    logic       exp_push;
    logic [8:0] exp_entry;
  } vec_t;

  vec_t       vecs [11];
  logic [8:0] sb_q [$];

  uart_rx_framer_if #(.DEPTH(DEPTH)) bus ();

  uart_rx_framer #(.DEPTH(DEPTH), .ESC_BYTE(8'h01)) dut (
    .CLK_I  (clk),
    .RST_NI (rst_n),
    .bus    (bus.slave)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: actual=timeout required=finish");
    $fatal(1, "watchdog expired");
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_total++;
    if (act === exp) begin
      n_pass++;
    end else begin
      $display("FAIL %s: actual=0x%0h required=0x%0h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic send_byte(input logic [7:0] d, input logic ferr);
    bus.RX_VALID_I     = 1'b1;
    bus.RX_DATA_I      = d;
    bus.RX_FRAME_ERR_I = ferr;
    tick();
    bus.RX_VALID_I     = 1'b0;
    bus.RX_FRAME_ERR_I = 1'b0;
  endtask

  // Compare the head with the scoreboard front, then pop it
  task automatic pop_check(input string name);
    logic [8:0] exp;
    if (sb_q.size() == 0) begin
      check({name, "_sb_empty"}, 32'(1), 32'(0));
    end else begin
      exp = sb_q.pop_front();
      check(name, 32'({bus.CMD_REC_O, bus.DATA_REC_O}), 32'(exp));
    end
    bus.READ_I = 1'b1;
    tick();
    bus.READ_I = 1'b0;
  endtask

  task automatic check_reset_outputs(input string tag);
    check({tag, "_empty"}, 32'(bus.RX_EMPTY_O), 32'(1));
    check({tag, "_full"},  32'(bus.RX_FULL_O),  32'(0));
    check({tag, "_fill"},  32'(bus.FILL_LEVEL_O), 32'(0));
    check({tag, "_ovf"},   32'(bus.OVERFLOW_O), 32'(0));
    check({tag, "_data"},  32'(bus.DATA_REC_O), 32'(0));
    check({tag, "_cmd"},   32'(bus.CMD_REC_O),  32'(0));
  endtask

  task automatic drain(input string tag);
    for (int i = 0; i < DEPTH + 1; i++) begin
      if (sb_q.size() != 0) pop_check(tag);
    end
    check({tag, "_empty_after"}, 32'(bus.RX_EMPTY_O), 32'(1));
  endtask

  initial begin
    n_total = 0;
    n_pass  = 0;
    bus.RX_VALID_I       = 1'b0;
    bus.RX_DATA_I        = 8'h00;
    bus.RX_FRAME_ERR_I   = 1'b0;
    bus.READ_I           = 1'b0;
    bus.CLEAR_OVERFLOW_I = 1'b0;
    rst_n = 1'b0;

    vecs[0]  = '{1'b0, 8'h41, 1'b1, 9'h041};
    vecs[1]  = '{1'b0, 8'h01, 1'b0, 9'h000};
    vecs[2]  = '{1'b0, 8'h02, 1'b1, 9'h102};
    vecs[3]  = '{1'b0, 8'h01, 1'b0, 9'h000};
    vecs[4]  = '{1'b0, 8'h01, 1'b1, 9'h001};
    vecs[5]  = '{1'b0, 8'h01, 1'b0, 9'h000};
    vecs[6]  = '{1'b1, 8'h33, 1'b0, 9'h000};
    vecs[7]  = '{1'b0, 8'h05, 1'b1, 9'h005};
    vecs[8]  = '{1'b0, 8'h01, 1'b0, 9'h000};
    vecs[9]  = '{1'b0, 8'hFF, 1'b1, 9'h1FF};
    vecs[10] = '{1'b0, 8'h00, 1'b1, 9'h000};

    #3;
    check_reset_outputs("rst0");
    @(posedge clk);
    #1;
    rst_n = 1'b1;

    // De-escape vectors: each byte's expected entry goes to the scoreboard
    for (int i = 0; i < 11; i++) begin
      send_byte(vecs[i].data, vecs[i].ferr);
      if (vecs[i].exp_push) sb_q.push_back(vecs[i].exp_entry);
      check($sformatf("vec%0d_fill", i), 32'(bus.FILL_LEVEL_O), 32'(sb_q.size()));
    end
    drain("vec_pop");

    // Fill past capacity: 0x18 must be dropped
    for (int i = 0; i < 9; i++) begin
      send_byte(8'h10 + 8'(i), 1'b0);
      if (i < DEPTH) sb_q.push_back({1'b0, 8'h10 + 8'(i)});
    end
    check("ovf_full", 32'(bus.RX_FULL_O), 32'(1));
    check("ovf_fill", 32'(bus.FILL_LEVEL_O), 32'(8));
    check("ovf_flag", 32'(bus.OVERFLOW_O), 32'(1));

    // Set wins over clear in the same cycle
    bus.CLEAR_OVERFLOW_I = 1'b1;
    send_byte(8'h19, 1'b0);
    bus.CLEAR_OVERFLOW_I = 1'b0;
    check("ovf_set_wins", 32'(bus.OVERFLOW_O), 32'(1));
    bus.CLEAR_OVERFLOW_I = 1'b1;
    tick();
    bus.CLEAR_OVERFLOW_I = 1'b0;
    check("ovf_cleared", 32'(bus.OVERFLOW_O), 32'(0));
    tick();
    check("ovf_sticky_low", 32'(bus.OVERFLOW_O), 32'(0));

    // Push and pop while full
    check("full_head", 32'({bus.CMD_REC_O, bus.DATA_REC_O}), 32'(sb_q[0]));
    void'(sb_q.pop_front());
    sb_q.push_back(9'h055);
    bus.READ_I = 1'b1;
    send_byte(8'h55, 1'b0);
    bus.READ_I = 1'b0;
    check("pp_full_fill", 32'(bus.FILL_LEVEL_O), 32'(8));
    check("pp_full_ovf", 32'(bus.OVERFLOW_O), 32'(0));
    check("pp_full_full", 32'(bus.RX_FULL_O), 32'(1));
    drain("full_pop");

    // Read while empty is ignored
    bus.READ_I = 1'b1;
    tick();
    bus.READ_I = 1'b0;
    check("rd_empty_fill", 32'(bus.FILL_LEVEL_O), 32'(0));
    check("rd_empty_empty", 32'(bus.RX_EMPTY_O), 32'(1));
    send_byte(8'h66, 1'b0);
    sb_q.push_back(9'h066);
    check("rd_empty_ptr", 32'(bus.FILL_LEVEL_O), 32'(1));
    drain("rd_empty_pop");

    // Push and pop on an empty FIFO: the push is stored
    bus.READ_I = 1'b1;
    send_byte(8'h77, 1'b0);
    bus.READ_I = 1'b0;
    sb_q.push_back(9'h077);
    check("pp_empty_fill", 32'(bus.FILL_LEVEL_O), 32'(1));
    drain("pp_empty_pop");

    // Asynchronous reset while escaped with three entries queued
    send_byte(8'h21, 1'b0);
    send_byte(8'h22, 1'b0);
    send_byte(8'h23, 1'b0);
    send_byte(8'h01, 1'b0);
    check("pre_rst_fill", 32'(bus.FILL_LEVEL_O), 32'(3));
    #3;
    rst_n = 1'b0;
    #1;
    check_reset_outputs("arst");
    sb_q.delete();
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    send_byte(8'h02, 1'b0);
    sb_q.push_back(9'h002);
    check("post_rst_fill", 32'(bus.FILL_LEVEL_O), 32'(1));
    check("post_rst_cmd", 32'(bus.CMD_REC_O), 32'(0));
    drain("post_rst_pop");

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end
endmodule

// File: doc/uart_rx_framer.md
UART_RX_FRAMER -- requirements
Module: uart_rx_framer

Interface
REQ-001 SHALL have parameter DEPTH, default 8, number of FIFO entries; must be a power of two, minimum 2.
REQ-002 SHALL have parameter ESC_BYTE, default 8'h01, escape byte marking that the next byte is a command or a literal.
REQ-003 SHALL have port CLK_I, input, 1, the single clock; all logic on rising edge.
REQ-004 SHALL have port RST_NI, input, 1, reset; asynchronous assert, active-low.
REQ-005 SHALL have port RX_VALID_I, input, 1, one-cycle strobe from the UART receiver that a byte is present.
REQ-006 SHALL have port RX_DATA_I, input, 8, received byte; qualified by RX_VALID_I.
REQ-007 SHALL have port RX_FRAME_ERR_I, input, 1, framing error on the current byte; qualified by RX_VALID_I.
REQ-008 SHALL have port READ_I, input, 1, pop request from the downstream TAP.
REQ-009 SHALL have port DATA_REC_O, output, 8, head-of-FIFO byte.
REQ-010 SHALL have port CMD_REC_O, output, 1, head-of-FIFO byte is a command.
REQ-011 SHALL have port RX_EMPTY_O, output, 1, FIFO holds no entries.
REQ-012 SHALL have port RX_FULL_O, output, 1, FIFO holds DEPTH entries.
REQ-013 SHALL have port FILL_LEVEL_O, output, $clog2(DEPTH)+1, current entry count.
REQ-014 SHALL have port OVERFLOW_O, output, 1, sticky flag: a byte was dropped.
REQ-015 SHALL have port CLEAR_OVERFLOW_I, input, 1, clears OVERFLOW_O.

Function
REQ-016 SHALL run a de-escape FSM with states IDLE and ESCAPED, advancing only on cycles with RX_VALID_I=1.
REQ-017 In IDLE, a byte equal to ESC_BYTE SHALL move the FSM to ESCAPED and write nothing.
REQ-018 In IDLE, any other byte SHALL be pushed as a data entry {cmd=0, byte}.
REQ-019 In ESCAPED, a byte equal to ESC_BYTE SHALL push the literal data entry {0, ESC_BYTE} and return to IDLE.
REQ-020 In ESCAPED, any other byte SHALL push a command entry {cmd=1, byte} and return to IDLE.
REQ-021 RX_VALID_I with RX_FRAME_ERR_I=1 SHALL discard the byte, push nothing, and force the FSM to IDLE.
REQ-022 FIFO entries SHALL be 9 bits wide, {cmd, byte}.
REQ-023 Read and write pointers SHALL be $clog2(DEPTH)+1 bits with natural wrap-around; full when the MSBs differ and the rest are equal; empty when all bits are equal.
REQ-024 FIFO output SHALL be show-ahead: while RX_EMPTY_O=0, DATA_REC_O/CMD_REC_O SHALL present the head combinationally from storage; while empty, both SHALL be 0.
REQ-025 A push SHALL be visible one cycle after the RX_VALID_I edge: RX_EMPTY_O falls and FILL_LEVEL_O updates on the next clock.
REQ-026 READ_I=1 with RX_EMPTY_O=0 SHALL pop the head at the clock edge.
REQ-027 READ_I while empty SHALL be ignored, with no pointer change.
REQ-028 A simultaneous push and pop SHALL leave FILL_LEVEL_O unchanged, including when full; the push is accepted.
REQ-029 A push while full without a same-cycle pop SHALL drop the entry and set OVERFLOW_O on the next clock; the FSM still advances.
REQ-030 OVERFLOW_O SHALL hold until CLEAR_OVERFLOW_I=1; if a new overflow and a clear occur in the same cycle, set SHALL win.
REQ-031 A simultaneous push and pop on an empty FIFO SHALL ignore the pop and store the push.
REQ-032 RX_FULL_O, RX_EMPTY_O and FILL_LEVEL_O SHALL be derived from the pointers and stay mutually consistent every cycle.

Reset
REQ-033 RST_NI=0 SHALL immediately, without waiting for a clock edge, force: FSM=IDLE, both pointers=0, RX_EMPTY_O=1, RX_FULL_O=0, FILL_LEVEL_O=0, OVERFLOW_O=0, DATA_REC_O=0, CMD_REC_O=0.
REQ-034 Reset mid-sequence (FSM=ESCAPED or FIFO non-empty) SHALL discard all stored entries and the pending escape; FIFO contents need not be cleared.
REQ-035 Release of RST_NI SHALL need no more than one clock before RX_VALID_I is honoured.

Verification
REQ-036 Bytes 0x41, 0x01, 0x02 -> two entries {0,0x41}, {1,0x02}; CMD_REC_O=1 on the second head.
REQ-037 Bytes 0x01, 0x01 -> one entry {0,0x01}; FSM back in IDLE; FILL_LEVEL_O=1.
REQ-038 Byte 0x01, then a byte with RX_FRAME_ERR_I=1, then 0x05 -> one entry {0,0x05}; no command flagged.
REQ-039 Nine data bytes 0x10..0x18 with DEPTH=8 and no reads -> RX_FULL_O=1, OVERFLOW_O=1, 0x18 lost; popping 8 times returns 0x10..0x17, then RX_EMPTY_O=1.
REQ-040 FIFO full, push 0x55 and READ_I in the same cycle -> FILL_LEVEL_O stays 8, OVERFLOW_O=0, 0x55 becomes the last entry.
REQ-041 Assert RST_NI low asynchronously while FSM=ESCAPED with 3 entries stored -> outputs take reset values before the next edge; a following 0x02 is stored as data {0,0x02}.
